// File: rtl/stall_mem_if.sv
// ============================================================================
// stall_mem_if : request/response bundle between the processor data port and
//                the multi-cycle word memory.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface stall_mem_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, done, stall, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, done, stall, err
    );
endinterface

`default_nettype wire

// File: rtl/stall_mem.sv
// ============================================================================
// stall_mem : multi-cycle 16-bit word memory; holds stall for LAT cycles per
//             access, pulses done on completion and err on illegal requests.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_mem #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LAT        = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    stall_mem_if.slave bus
);

    localparam int         WORDS    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [DEPTH_LOG2-1:0]   lidx;
    logic [15:0]             ldata;
    logic                    lwr;
    logic [15:0]             data_reg;
    logic                    err_reg;
    logic                    accept;
    logic                    reject;
    logic [15:0]             mem [WORDS];
    logic                    unused_addr_bits;

    // Upper address bits only select aliases of the same word.
    assign unused_addr_bits = ^bus.addr[15:DEPTH_LOG2+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                if ((bus.rd ^ bus.wr) && !bus.addr[0]) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end else if (bus.rd | bus.wr) begin
                    reject    = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            lidx     <= '0;
            ldata    <= 16'h0000;
            lwr      <= 1'b0;
            data_reg <= 16'h0000;
            err_reg  <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            err_reg <= reject;
            if (accept) begin
                lidx  <= bus.addr[DEPTH_LOG2:1];
                ldata <= bus.data_in;
                lwr   <= bus.wr;
                cnt   <= CNT_INIT;
            end
            if (state == BUSY) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (lwr) begin
                    mem[lidx] <= ldata;
                end else begin
                    data_reg <= mem[lidx];
                end
            end
        end
    end

    // All status outputs decode registered state only.
    assign bus.stall    = (state == BUSY);
    assign bus.done     = (state == DONE);
    assign bus.err      = err_reg;
    assign bus.data_out = data_reg;

endmodule

`default_nettype wire

// File: tb/tb_stall_mem.sv
// ============================================================================
// tb_stall_mem : directed self-checking bench for stall_mem (LAT=4, 256 words).
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stall_mem;

    localparam int LAT = 4;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    stall_mem_if bus ();

    stall_mem #(
        .DEPTH_LOG2 (8),
        .LAT        (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, optionally alter addr/data once accepted, then check
    // the stall window, the done pulse and the data_out behaviour.
    task automatic access(input logic is_wr, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] pa, input logic [15:0] pd,
                          input logic [15:0] exp_rd);
        logic [15:0] prev;
        logic        held;
        int          n;
        prev        = bus.data_out;
        bus.addr    = a;
        bus.data_in = d;
        bus.rd      = ~is_wr;
        bus.wr      = is_wr;
        tick();
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = pa;
        bus.data_in = pd;
        n    = 0;
        held = 1'b1;
        while (bus.stall === 1'b1 && n < 20) begin
            n++;
            if (bus.done !== 1'b0) held = 1'b0;
            if (bus.data_out !== prev) held = 1'b0;
            tick();
        end
        chk16("stall_cycles", 16'(n), 16'(LAT));
        chk1("quiet_during_busy", held, 1'b1);
        chk1("done_pulse", bus.done, 1'b1);
        chk1("err_quiet", bus.err, 1'b0);
        if (is_wr) chk16("dout_kept_on_write", bus.data_out, prev);
        else       chk16("read_data", bus.data_out, exp_rd);
        tick();
        chk1("done_one_cycle", bus.done, 1'b0);
        chk1("stall_after_done", bus.stall, 1'b0);
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        rst         = 1'b1;
        bus.addr    = 16'h0000;
        bus.data_in = 16'h0000;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        tick();
        tick();
        chk1("rst_stall", bus.stall, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk16("rst_dout", bus.data_out, 16'h0000);
        rst = 1'b0;
        tick();

        // Basic write then read back
        access(1'b1, 16'h0010, 16'hBEEF, 16'h0010, 16'hBEEF, 16'h0000);
        access(1'b0, 16'h0010, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF);
        // Unwritten word reads zero; BEEF held through the busy window
        access(1'b0, 16'h0020, 16'h0000, 16'h0020, 16'h0000, 16'h0000);
        access(1'b0, 16'h0010, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF);

        // rd & wr together, held three cycles
        bus.addr    = 16'h0004;
        bus.data_in = 16'h1111;
        bus.rd      = 1'b1;
        bus.wr      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("both_err", bus.err, 1'b1);
            chk1("both_no_stall", bus.stall, 1'b0);
            chk1("both_no_done", bus.done, 1'b0);
        end
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        tick();
        chk1("both_err_clears", bus.err, 1'b0);
        chk16("dout_kept_on_reject", bus.data_out, 16'hBEEF);

        // Misaligned read
        bus.addr = 16'h0003;
        bus.rd   = 1'b1;
        tick();
        bus.rd = 1'b0;
        chk1("misalign_err", bus.err, 1'b1);
        chk1("misalign_no_stall", bus.stall, 1'b0);
        tick();
        chk1("misalign_err_one", bus.err, 1'b0);
        chk1("misalign_no_stall2", bus.stall, 1'b0);
        access(1'b0, 16'h0004, 16'h0000, 16'h0004, 16'h0000, 16'h0000);

        // Address wrap at 512 bytes
        access(1'b1, 16'h0002, 16'h1234, 16'h0002, 16'h1234, 16'h0000);
        access(1'b0, 16'h0202, 16'h0000, 16'h0202, 16'h0000, 16'h1234);

        // Inputs changed during BUSY must not affect the latched request
        access(1'b1, 16'h0008, 16'h5555, 16'h000A, 16'hAAAA, 16'h0000);
        access(1'b0, 16'h000A, 16'h0000, 16'h000A, 16'h0000, 16'h0000);
        access(1'b0, 16'h0008, 16'h0000, 16'h0008, 16'h0000, 16'h5555);

        // Reset during the second BUSY cycle of a write
        bus.addr    = 16'h0006;
        bus.data_in = 16'h7777;
        bus.wr      = 1'b1;
        tick();
        bus.wr = 1'b0;
        chk1("rstw_busy1", bus.stall, 1'b1);
        tick();
        chk1("rstw_busy2", bus.stall, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rstw_stall", bus.stall, 1'b0);
        chk1("rstw_done", bus.done, 1'b0);
        chk1("rstw_err", bus.err, 1'b0);
        chk16("rstw_dout", bus.data_out, 16'h0000);
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            chk1("rstw_no_done", bus.done, 1'b0);
        end
        access(1'b0, 16'h0006, 16'h0000, 16'h0006, 16'h0000, 16'h0000);
        access(1'b0, 16'h0010, 16'h0000, 16'h0010, 16'h0000, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
